samx_dram_arbiter: RTL and testbench
====================================

Name: samx_dram_arbiter

Overview:
- Arbitrates the SAMx4 DRAM port between three requesters: refresh (internal timer), video fetch and CPU.
- Sequences each granted access through row, column and precharge phases, driving nRAS, nCAS, nWE and the multiplexed row/column address.
- Sits between the CPU bus decode, the video address counter (whose fetch rate is set by the video-mode register) and the DRAM pins.

Parameters:
- ADDR_W, 16, requester address width; row = addr[ADDR_W/2-1:0], column = addr[ADDR_W-1:ADDR_W/2].
- RAS_CYCLES, 2, clocks in RAS phase (nRAS low, row on ma), range 1..15.
- CAS_CYCLES, 2, clocks in CAS phase (nRAS and nCAS low, column on ma), range 1..15.
- PRE_CYCLES, 1, clocks in precharge phase (both strobes high), range 1..15.
- REFRESH_INTERVAL, 64, clocks between refresh requests, minimum 16.
- MAX_VID_RUN, 4, consecutive video grants allowed while cpu_req is pending.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request, held until cpu_ack.
- cpu_we  in  1  CPU write when 1; sampled with cpu_addr at grant.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_ack  out  1  one-clock pulse in the final CAS cycle of a CPU access.
- vid_req  in  1  video fetch request, held until vid_ack.
- vid_addr  in  ADDR_W  video fetch address.
- vid_ack  out  1  one-clock pulse in the final CAS cycle of a video access; read data is valid on this cycle.
- ma  out  ADDR_W/2  multiplexed DRAM address.
- nras  out  1  row strobe, active low.
- ncas  out  1  column strobe, active low.
- nwe  out  1  write enable, active low.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Registered outputs: all outputs are registered.
- Reset values:
  - nras=1, ncas=1, nwe=1.
  - cpu_ack=0, vid_ack=0, busy=0, ma=0.
  - State is IDLE; refresh counter, refresh row and video-run counter are 0; refresh pending is 0.
- Reset mid-access: the access is abandoned at the next edge, with strobes high and no ack.
- States: IDLE, RAS, CAS, PRE.
  - Phase counter reloads on every state entry.
  - IDLE->RAS when any request is pending.
  - RAS->CAS after RAS_CYCLES clocks; for a refresh grant, RAS->PRE instead (RAS-only refresh).
  - CAS->PRE after CAS_CYCLES clocks.
  - PRE->IDLE after PRE_CYCLES clocks.
- Grant priority, evaluated in IDLE only:
  - Refresh pending beats video and CPU.
  - Video beats CPU, except when the video-run counter has reached MAX_VID_RUN with cpu_req high; CPU wins in that case.
  - The video-run counter increments on each video grant while cpu_req is high, saturates at MAX_VID_RUN, and clears on a CPU grant or whenever cpu_req is low in IDLE.
- Address and write latch: at grant, the winning address and cpu_we are latched.
  - ma = row part during RAS, column part during CAS, and holds its last value elsewhere.
  - For refresh, ma = refresh row counter during RAS; the counter increments (wrapping mod 2^(ADDR_W/2)) on PRE entry.
- Write strobe: nwe=0 during CAS only, and only for a CPU grant with cpu_we=1.
- Acks: exactly one ack pulse per granted CPU or video access, in its final CAS cycle. Refresh produces no ack.
- Latency: a request sampled in IDLE gives nras=0 on the next clock. Minimum cycle = 1 + RAS_CYCLES + CAS_CYCLES + PRE_CYCLES (6 at defaults).
- Refresh timer:
  - Free-running counter 0..REFRESH_INTERVAL-1, wrapping.
  - Reaching terminal count sets refresh pending.
  - Pending clears on refresh grant; terminal count and grant in the same cycle leaves pending = 1.
  - A second expiry while pending is already set is absorbed; the flag stays 1.
- Requester handshake:
  - A request dropped before grant is simply not served.
  - A requester must not change its address while its request is high.
  - A request held high through its ack is treated as a new request in the next IDLE.

Decomposition:
- Shared package samx_pkg:
  - State enumeration (IDLE/RAS/CAS/PRE).
  - Grant-source encoding (GNT_NONE/REF/VID/CPU).
  - Default timing constants.
- Sub-module samx_refresh_timer: owns the interval counter, pending flag (inputs: grant clear) and refresh row counter. The arbiter FSM stays in the top level.

Test Plan:
- Single CPU read, defaults: cpu_req=1 with addr 0x3412 at cycle 0 -> nras=0 on cycles 1-4 with ma=0x12 on 1-2 and 0x34 on 3-4; ncas=0 on 3-4; cpu_ack on cycle 4 only; nras=1 on cycle 5; busy falls on cycle 6.
- CPU write: cpu_we=1 -> nwe=0 exactly on the two CAS cycles. Video write attempt is impossible; nwe stays 1 for every video grant.
- Contention: cpu_req and vid_req held continuously -> grant order V,V,V,V,C,V,V,V,V,C; one ack per grant.
- Refresh: no requesters for 64 clocks -> RAS-only cycle with ncas=1, ma=0, no ack. The next refresh drives ma=1. Refresh pending coincident with vid_req -> refresh served first.
- Reset mid-CAS of a CPU access -> next edge: nras=ncas=nwe=1, no cpu_ack, busy=0. A held request is then served from a fresh RAS.
- Starvation of refresh: continuous CPU and video traffic for 200 clocks -> at least 3 refresh cycles observed, each within REFRESH_INTERVAL + 7 clocks of its expiry.

Source files
------------

// File: rtl/samx_pkg.sv
// Shared encodings and default timing for the SAMx4 DRAM arbiter.
package samx_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RAS  = 2'd1;
   localparam logic [1:0] ST_CAS  = 2'd2;
   localparam logic [1:0] ST_PRE  = 2'd3;

   // Grant source encoding
   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_REF  = 2'd1;
   localparam logic [1:0] GNT_VID  = 2'd2;
   localparam logic [1:0] GNT_CPU  = 2'd3;

   // Default timing
   localparam int unsigned DEF_ADDR_W           = 16;
   localparam int unsigned DEF_RAS_CYCLES       = 2;
   localparam int unsigned DEF_CAS_CYCLES       = 2;
   localparam int unsigned DEF_PRE_CYCLES       = 1;
   localparam int unsigned DEF_REFRESH_INTERVAL = 64;
   localparam int unsigned DEF_MAX_VID_RUN      = 4;

   // Phase counter load value: a phase of n clocks counts n-1 down to 0.
   function automatic logic [3:0] phase_load(input int unsigned n);
      return 4'(n - 1);
   endfunction

endpackage

// File: rtl/samx_refresh_timer.sv
// Refresh interval timer, pending flag and refresh row counter.
module samx_refresh_timer
   import samx_pkg::*;
#(
   parameter int unsigned INTERVAL = DEF_REFRESH_INTERVAL,
   parameter int unsigned ROW_W    = DEF_ADDR_W / 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             grant,
   input  logic             row_adv,
   output logic             pending,
   output logic [ROW_W-1:0] row
);

   localparam int unsigned CNT_W = $clog2(INTERVAL);

   logic [CNT_W-1:0] count;
   logic             tc;

   assign tc = (count == CNT_W'(INTERVAL - 1));

   // Free-running interval counter, wraps at terminal count
   always_ff @(posedge clk) begin
      if (reset)   count <= '0;
      else if (tc) count <= '0;
      else         count <= count + CNT_W'(1);
   end

   // Pending flag: a fresh expiry wins over a grant in the same cycle
   always_ff @(posedge clk) begin
      if (reset)      pending <= 1'b0;
      else if (tc)    pending <= 1'b1;
      else if (grant) pending <= 1'b0;
   end

   // Row counter advances as each refresh leaves RAS
   always_ff @(posedge clk) begin
      if (reset)        row <= '0;
      else if (row_adv) row <= row + ROW_W'(1);
   end

endmodule

// File: rtl/samx_dram_arbiter.sv
// SAMx4 DRAM port arbiter: refresh > video > CPU with a video-run limit.
//
//   state | meaning
//   IDLE  | strobes high, grant evaluated every clock
//   RAS   | nRAS low, row (or refresh row) on ma
//   CAS   | nRAS and nCAS low, column on ma; ack in last clock
//   PRE   | both strobes high, precharge
module samx_dram_arbiter
   import samx_pkg::*;
#(
   parameter int unsigned ADDR_W           = DEF_ADDR_W,
   parameter int unsigned RAS_CYCLES       = DEF_RAS_CYCLES,
   parameter int unsigned CAS_CYCLES       = DEF_CAS_CYCLES,
   parameter int unsigned PRE_CYCLES       = DEF_PRE_CYCLES,
   parameter int unsigned REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
   parameter int unsigned MAX_VID_RUN      = DEF_MAX_VID_RUN
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [ADDR_W-1:0]   cpu_addr,
   output logic                cpu_ack,
   input  logic                vid_req,
   input  logic [ADDR_W-1:0]   vid_addr,
   output logic                vid_ack,
   output logic [ADDR_W/2-1:0] ma,
   output logic                nras,
   output logic                ncas,
   output logic                nwe,
   output logic                busy
);

   localparam int unsigned HALF = ADDR_W / 2;
   localparam int unsigned VR_W = $clog2(MAX_VID_RUN + 1);

   logic [1:0]        state, state_nx;
   logic [1:0]        gnt, gnt_nx;
   logic [3:0]        cnt, cnt_nx;
   logic [ADDR_W-1:0] addr_lat, addr_nx;
   logic              we_lat, we_nx;
   logic [VR_W-1:0]   vrun, vrun_nx;
   logic              ref_pend, ref_grant, ref_adv;
   logic [HALF-1:0]   ref_row;

   samx_refresh_timer #(
      .INTERVAL (REFRESH_INTERVAL),
      .ROW_W    (HALF)
   ) u_refresh (
      .clk     (clk),
      .reset   (reset),
      .grant   (ref_grant),
      .row_adv (ref_adv),
      .pending (ref_pend),
      .row     (ref_row)
   );

   // Next-state, grant selection and phase counting
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      gnt_nx    = gnt;
      addr_nx   = addr_lat;
      we_nx     = we_lat;
      vrun_nx   = vrun;
      ref_grant = 1'b0;
      ref_adv   = 1'b0;
      case (state)
         ST_IDLE: begin
            gnt_nx = GNT_NONE;
            if (!cpu_req) vrun_nx = '0;
            if (ref_pend) begin
               gnt_nx    = GNT_REF;
               we_nx     = 1'b0;
               ref_grant = 1'b1;
            end else if (vid_req && !(cpu_req && vrun == VR_W'(MAX_VID_RUN))) begin
               gnt_nx  = GNT_VID;
               addr_nx = vid_addr;
               we_nx   = 1'b0;
               if (cpu_req) vrun_nx = vrun + VR_W'(1);
            end else if (cpu_req) begin
               gnt_nx  = GNT_CPU;
               addr_nx = cpu_addr;
               we_nx   = cpu_we;
               vrun_nx = '0;
            end
            if (ref_pend || vid_req || cpu_req) begin
               state_nx = ST_RAS;
               cnt_nx   = phase_load(RAS_CYCLES);
            end
         end
         ST_RAS: begin
            if (cnt != 4'd0) begin
               cnt_nx = cnt - 4'd1;
            end else if (gnt == GNT_REF) begin
               state_nx = ST_PRE;
               cnt_nx   = phase_load(PRE_CYCLES);
               ref_adv  = 1'b1;
            end else begin
               state_nx = ST_CAS;
               cnt_nx   = phase_load(CAS_CYCLES);
            end
         end
         ST_CAS: begin
            if (cnt != 4'd0) begin
               cnt_nx = cnt - 4'd1;
            end else begin
               state_nx = ST_PRE;
               cnt_nx   = phase_load(PRE_CYCLES);
            end
         end
         ST_PRE: begin
            if (cnt != 4'd0) begin
               cnt_nx = cnt - 4'd1;
            end else begin
               state_nx = ST_IDLE;
               cnt_nx   = 4'd0;
            end
         end
         default: begin
            state_nx = ST_IDLE;
            cnt_nx   = 4'd0;
         end
      endcase
   end

   // State, latches and registered DRAM-side outputs derived from next state
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         gnt      <= GNT_NONE;
         cnt      <= 4'd0;
         addr_lat <= '0;
         we_lat   <= 1'b0;
         vrun     <= '0;
         nras     <= 1'b1;
         ncas     <= 1'b1;
         nwe      <= 1'b1;
         cpu_ack  <= 1'b0;
         vid_ack  <= 1'b0;
         busy     <= 1'b0;
         ma       <= '0;
      end else begin
         state    <= state_nx;
         gnt      <= gnt_nx;
         cnt      <= cnt_nx;
         addr_lat <= addr_nx;
         we_lat   <= we_nx;
         vrun     <= vrun_nx;
         nras     <= !(state_nx == ST_RAS || state_nx == ST_CAS);
         ncas     <= !(state_nx == ST_CAS);
         nwe      <= !(state_nx == ST_CAS && gnt_nx == GNT_CPU && we_nx);
         cpu_ack  <= (state_nx == ST_CAS) && (cnt_nx == 4'd0) && (gnt_nx == GNT_CPU);
         vid_ack  <= (state_nx == ST_CAS) && (cnt_nx == 4'd0) && (gnt_nx == GNT_VID);
         busy     <= (state_nx != ST_IDLE);
         if (state == ST_IDLE && state_nx == ST_RAS)
            ma <= (gnt_nx == GNT_REF) ? ref_row : addr_nx[HALF-1:0];
         else if (state == ST_RAS && state_nx == ST_CAS)
            ma <= addr_lat[ADDR_W-1:HALF];
      end
   end

endmodule

// File: tb/tb_samx_dram_arbiter.sv
// Bench for samx_dram_arbiter: directed scenarios plus a transaction-level
// scoreboard that schedules each grant's expected pin waveform.
module tb_samx_dram_arbiter;

   localparam int NMAX = 2048;
   localparam int R    = 2;
   localparam int C    = 2;
   localparam int P    = 1;
   localparam int INTV = 64;
   localparam int MAXV = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, vid_req = 1'b0;
   logic [15:0] cpu_addr = '0, vid_addr = '0;
   logic        cpu_ack, vid_ack, nras, ncas, nwe, busy;
   logic [7:0]  ma;

   samx_dram_arbiter #(
      .ADDR_W(16), .RAS_CYCLES(R), .CAS_CYCLES(C), .PRE_CYCLES(P),
      .REFRESH_INTERVAL(INTV), .MAX_VID_RUN(MAXV)
   ) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
      .ma(ma), .nras(nras), .ncas(ncas), .nwe(nwe), .busy(busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int c, vrun, free_at, ref_row, cur_kind;
   bit ref_pend;
   bit e_nras[NMAX], e_ncas[NMAX], e_nwe[NMAX], e_cack[NMAX], e_vack[NMAX], e_busy[NMAX];
   int e_ma[NMAX];

   function automatic void model_init();
      c = 0; vrun = 0; free_at = 0; ref_row = 0; cur_kind = 0; ref_pend = 0;
      for (int i = 0; i < NMAX; i++) begin
         e_nras[i] = 1; e_ncas[i] = 1; e_nwe[i] = 1;
         e_cack[i] = 0; e_vack[i] = 0; e_busy[i] = 0; e_ma[i] = 0;
      end
   endfunction

   // kind: 1 refresh, 2 video, 3 cpu; grant decided in cycle t
   function automatic void schedule(int t, int kind, logic [15:0] a, logic we);
      int len, strobe, row, col;
      len    = (kind == 1) ? R + P : R + C + P;
      strobe = (kind == 1) ? R : R + C;
      row    = (kind == 1) ? ref_row : int'(a[7:0]);
      col    = int'(a[15:8]);
      for (int i = t + 1; i < NMAX; i++) e_ma[i] = row;
      for (int i = 1; i <= len; i++) if (t + i < NMAX) e_busy[t+i] = 1;
      for (int i = 1; i <= strobe; i++) if (t + i < NMAX) e_nras[t+i] = 0;
      if (kind != 1) begin
         for (int i = t + R + 1; i < NMAX; i++) e_ma[i] = col;
         for (int i = R + 1; i <= R + C; i++) if (t + i < NMAX) begin
            e_ncas[t+i] = 0;
            if (kind == 3 && we) e_nwe[t+i] = 0;
         end
         if (t + R + C < NMAX) begin
            if (kind == 3) e_cack[t+R+C] = 1;
            else           e_vack[t+R+C] = 1;
         end
      end else begin
         ref_row = (ref_row + 1) % 256;
      end
      free_at = t + 1 + len;
   endfunction

   function automatic void model_step();
      int kind = 0;
      if (c >= free_at) begin
         if (ref_pend) kind = 1;
         else if (vid_req && !(cpu_req && vrun >= MAXV)) kind = 2;
         else if (cpu_req) kind = 3;
         if (!cpu_req) vrun = 0;
         else if (kind == 2) vrun = (vrun < MAXV) ? vrun + 1 : MAXV;
         else if (kind == 3) vrun = 0;
         if (kind == 1) begin ref_pend = 0; schedule(c, 1, 16'h0, 1'b0); end
         if (kind == 2) schedule(c, 2, vid_addr, 1'b0);
         if (kind == 3) schedule(c, 3, cpu_addr, cpu_we);
         if (kind != 0) cur_kind = kind;
      end
      if (c % INTV == INTV - 1) ref_pend = 1;
   endfunction

   // one clock: score current outputs, advance model with current inputs
   task automatic tick();
      logic [13:0] got, exp;
      got = {cpu_ack, vid_ack, nras, ncas, nwe, busy, ma};
      exp = {e_cack[c], e_vack[c], e_nras[c], e_ncas[c], e_nwe[c], e_busy[c], 8'(e_ma[c])};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL scoreboard cycle %0d: cack/vack/nras/ncas/nwe/busy/ma got %b expected %b", c, got, exp);
      end
      model_step();
      c++;
      if (c >= NMAX) begin
         $display("FAIL cycle budget: segment exceeded %0d cycles", NMAX);
         $fatal(1);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_init();
   endtask

   task automatic drive_random(int pc, int pv);
      if (cpu_req) begin
         if (e_cack[c]) begin
            if ($urandom_range(0, 3) != 0) cpu_req = 1'b0;
         end else if (!(c < free_at && cur_kind == 3) && $urandom_range(0, 49) == 0) begin
            cpu_req = 1'b0;
         end
      end else if ($urandom_range(0, 99) < pc) begin
         cpu_req = 1'b1; cpu_addr = 16'($urandom); cpu_we = 1'($urandom_range(0, 1));
      end
      if (vid_req) begin
         if (e_vack[c]) begin
            if ($urandom_range(0, 3) != 0) vid_req = 1'b0;
         end else if (!(c < free_at && cur_kind == 2) && $urandom_range(0, 49) == 0) begin
            vid_req = 1'b0;
         end
      end else if ($urandom_range(0, 99) < pv) begin
         vid_req = 1'b1; vid_addr = 16'($urandom);
      end
   endtask

   task automatic test_reset();
      do_reset();
      cpu_req = 1; cpu_addr = 16'hFFFF; cpu_we = 1;
      for (int k = 0; k < 4; k++) tick();
      do_reset();
      cpu_req = 0; cpu_we = 0;
      vectors++;
      if ({cpu_ack, vid_ack, nras, ncas, nwe, busy, ma} !== {2'b00, 4'b1110, 8'h00}) begin
         miscompares++;
         $display("FAIL reset_values: got %b expected %b", {cpu_ack, vid_ack, nras, ncas, nwe, busy, ma}, 14'b00_1110_00000000);
      end
      for (int k = 0; k < 4; k++) tick();
   endtask

   task automatic test_cpu_read();
      logic [12:0] got, exp;
      do_reset();
      cpu_req = 1; cpu_addr = 16'h3412; cpu_we = 0;
      for (int k = 0; k < 8; k++) begin
         exp[12] = !(k >= 1 && k <= 4);
         exp[11] = !(k == 3 || k == 4);
         exp[10] = (k == 4);
         exp[9]  = (k >= 1 && k <= 5);
         exp[8]  = 1'b0;
         exp[7:0] = (k == 0) ? 8'h00 : (k <= 2) ? 8'h12 : 8'h34;
         got = {nras, ncas, cpu_ack, busy, vid_ack, ma};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL cpu_read cycle %0d: nras/ncas/ack/busy/vack/ma got %b expected %b", k, got, exp);
         end
         if (k == 4) cpu_req = 0;
         tick();
      end
   endtask

   task automatic test_cpu_write();
      int acks = 0;
      do_reset();
      cpu_req = 1; cpu_addr = 16'hBEEF; cpu_we = 1;
      for (int k = 0; k < 8; k++) begin
         vectors++;
         if (nwe !== !(k == 3 || k == 4)) begin
            miscompares++;
            $display("FAIL cpu_write nwe cycle %0d: got %b expected %b", k, nwe, !(k == 3 || k == 4));
         end
         if (k == 4) begin cpu_req = 0; cpu_we = 0; end
         tick();
      end
      vid_req = 1; vid_addr = 16'h1234;
      for (int k = 0; k < 24; k++) begin
         vectors++;
         if (nwe !== 1'b1) begin
            miscompares++;
            $display("FAIL video_nwe cycle %0d: got %b expected 1", k, nwe);
         end
         if (vid_ack) begin acks++; vid_addr = 16'($urandom); end
         if (acks == 3) vid_req = 0;
         tick();
      end
   endtask

   task automatic test_contention();
      string exp_order = "VVVVCVVVVC";
      byte   order[$];
      do_reset();
      cpu_req = 1; cpu_addr = 16'h0A0B; cpu_we = 0;
      vid_req = 1; vid_addr = 16'h0C0D;
      for (int k = 0; k < 80 && order.size() < 10; k++) begin
         if (cpu_ack) order.push_back("C");
         if (vid_ack) order.push_back("V");
         tick();
      end
      cpu_req = 0; vid_req = 0;
      vectors++;
      if (order.size() != 10) begin
         miscompares++;
         $display("FAIL contention ack count: got %0d expected 10 within 80 cycles", order.size());
      end
      for (int i = 0; i < order.size() && i < 10; i++) begin
         vectors++;
         if (order[i] !== exp_order[i]) begin
            miscompares++;
            $display("FAIL contention grant %0d: got %s expected %s", i, string'(order[i]), string'(exp_order[i]));
         end
      end
      for (int k = 0; k < 6; k++) tick();
   endtask

   task automatic test_refresh();
      do_reset();
      cpu_req = 0; vid_req = 0;
      for (int k = 0; k < 206; k++) begin
         if (k < 192) begin
            vectors++;
            if ((cpu_ack | vid_ack | !ncas) !== 1'b0) begin
               miscompares++;
               $display("FAIL refresh_quiet cycle %0d: ack/ncas activity cack=%b vack=%b ncas=%b", k, cpu_ack, vid_ack, ncas);
            end
         end
         if (k == 65 || k == 66 || k == 129 || k == 193) begin
            logic [9:0] exp;
            exp = {2'b01, (k < 100) ? 8'h00 : (k < 150) ? 8'h01 : 8'h02};
            vectors++;
            if ({nras, ncas, ma} !== exp) begin
               miscompares++;
               $display("FAIL refresh_ras cycle %0d: nras/ncas/ma got %b expected %b", k, {nras, ncas, ma}, exp);
            end
         end
         if (k == 192) begin vid_req = 1; vid_addr = 16'hABCD; end
         if (k == 200) begin
            vectors++;
            if ({vid_ack, ma} !== {1'b1, 8'hAB}) begin
               miscompares++;
               $display("FAIL refresh_before_video: vack/ma got %b expected %b", {vid_ack, ma}, 9'h1AB);
            end
            vid_req = 0;
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      cpu_req = 1; cpu_addr = 16'h5678; cpu_we = 1;
      for (int k = 0; k < 3; k++) tick();
      vectors++;
      if ({ncas, nwe} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_mid precondition: ncas/nwe got %b expected 00", {ncas, nwe});
      end
      do_reset();
      vectors++;
      if ({nras, ncas, nwe, cpu_ack, busy} !== 5'b11100) begin
         miscompares++;
         $display("FAIL reset_mid abandon: nras/ncas/nwe/ack/busy got %b expected 11100", {nras, ncas, nwe, cpu_ack, busy});
      end
      for (int k = 0; k < 8; k++) begin
         if (k == 1 || k == 4) begin
            logic [9:0] exp;
            exp = (k == 1) ? {2'b00, 8'h78} : {2'b01, 8'h56};
            vectors++;
            if ({nras, cpu_ack, ma} !== exp) begin
               miscompares++;
               $display("FAIL reset_mid fresh cycle %0d: nras/ack/ma got %b expected %b", k, {nras, cpu_ack, ma}, exp);
            end
         end
         if (k == 4) begin cpu_req = 0; cpu_we = 0; end
         tick();
      end
   endtask

   task automatic test_starvation();
      int  starts[$];
      bit  prev_nras = 1, saw_cas = 0;
      int  st = 0;
      do_reset();
      cpu_req = 1; cpu_addr = 16'h2211; cpu_we = 1;
      vid_req = 1; vid_addr = 16'h4433;
      for (int k = 0; k < 220; k++) begin
         if (prev_nras && !nras) begin st = k; saw_cas = 0; end
         if (!ncas) saw_cas = 1;
         if (!prev_nras && nras && !saw_cas) starts.push_back(st);
         prev_nras = nras;
         tick();
      end
      cpu_req = 0; vid_req = 0;
      vectors++;
      if (starts.size() < 3) begin
         miscompares++;
         $display("FAIL starvation refresh count: got %0d expected >= 3", starts.size());
      end
      for (int i = 0; i < 3 && i < starts.size(); i++) begin
         vectors++;
         if (!(starts[i] > INTV * i + INTV - 1 && starts[i] <= INTV * i + INTV - 1 + INTV + 7)) begin
            miscompares++;
            $display("FAIL starvation refresh %0d: started cycle %0d, expiry at %0d", i, starts[i], INTV * i + INTV - 1);
         end
      end
      for (int k = 0; k < 8; k++) tick();
   endtask

   task automatic test_random(int n, int pc, int pv);
      do_reset();
      cpu_req = 0; vid_req = 0;
      for (int k = 0; k < n; k++) begin
         drive_random(pc, pv);
         tick();
      end
      cpu_req = 0; vid_req = 0;
      for (int k = 0; k < 10; k++) tick();
   endtask

   initial begin
      test_reset();
      test_cpu_read();
      test_cpu_write();
      test_contention();
      test_refresh();
      test_reset_mid();
      test_starvation();
      test_random(1500, 30, 30);
      test_random(600, 80, 80);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
